// File: rtl/tl_phase_scheduler.sv
// Demand-driven four-road intersection phase scheduler: latched requests, round-robin
// arbitration, occupancy-based green extension and emergency preemption.
module tl_phase_scheduler #(
  parameter logic [15:0] MIN_GREEN_CLOCKS = 16'd5,
  parameter logic [15:0] MAX_GREEN_CLOCKS = 16'd12,
  parameter logic [15:0] YELLOW_CLOCKS    = 16'd2,
  parameter logic [15:0] ALL_RED_CLOCKS   = 16'd2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req,
  input  logic [2:0] i_occ,
  input  logic       i_emg,
  input  logic [1:0] i_emg_phase,
  output logic [2:0] o_r1_ryg,
  output logic [2:0] o_r2_ryg,
  output logic [2:0] o_r3_ryg,
  output logic [2:0] o_r4_ryg,
  output logic       o_r4_green_l,
  output logic [1:0] o_phase,
  output logic       o_phase_start,
  output logic       o_emg_active
);

  typedef enum logic [1:0] {ST_STARTUP, ST_GREEN, ST_YELLOW, ST_ALL_RED} state_e;

  localparam logic [1:0] PH_NS = 2'd0;
  localparam logic [1:0] PH_EW = 2'd1;
  localparam logic [1:0] PH_L4 = 2'd2;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_e      state;
  logic [15:0] tmr;
  logic [15:0] g_cnt;
  logic [2:0]  pending;
  logic [1:0]  phase_q;
  logic        start_q;

  logic       emg_valid, emg_hold, other_pending, min_done, max_done, green_exit, select_now;
  logic [2:0] cur_mask, req_eff, pending_d;
  logic [1:0] rr1, rr2, next_phase;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    emg_valid     = i_emg && (i_emg_phase != 2'd3);
    emg_hold      = emg_valid && (i_emg_phase == phase_q);
    cur_mask      = 3'b001 << phase_q;
    other_pending = |(pending & ~cur_mask);
    min_done      = g_cnt >= (MIN_GREEN_CLOCKS - 16'd1);
    max_done      = g_cnt >= (MAX_GREEN_CLOCKS - 16'd1);
    // Emergency for another phase cuts green short; emergency for this phase pins it.
    green_exit    = (emg_valid && (i_emg_phase != phase_q)) ||
                    (!emg_hold && other_pending && min_done && (!i_occ[phase_q] || max_done));
    select_now    = ((state == ST_STARTUP) || (state == ST_ALL_RED)) && (tmr == 16'd0);

    rr1 = (phase_q == PH_L4) ? PH_NS : phase_q + 2'd1;
    rr2 = (rr1 == PH_L4) ? PH_NS : rr1 + 2'd1;
    if (emg_valid)             next_phase = i_emg_phase;
    else if (pending[rr1])     next_phase = rr1;
    else if (pending[rr2])     next_phase = rr2;
    else if (pending[phase_q]) next_phase = phase_q;
    else                       next_phase = PH_NS;

    // Requests for the phase being served are dropped; the grant clear beats a same-cycle set.
    req_eff   = (state == ST_GREEN) ? (i_req & ~cur_mask) : i_req;
    pending_d = pending | req_eff;
    if (select_now) pending_d = pending_d & ~(3'b001 << next_phase);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_STARTUP;
      tmr     <= ALL_RED_CLOCKS - 16'd1;
      g_cnt   <= 16'd0;
      pending <= 3'b000;
      phase_q <= PH_NS;
      start_q <= 1'b0;
    end else begin
      pending <= pending_d;
      start_q <= 1'b0;
      case (state)
        ST_STARTUP, ST_ALL_RED: begin
          if (tmr == 16'd0) begin
            state   <= ST_GREEN;
            phase_q <= next_phase;
            start_q <= 1'b1;
            g_cnt   <= 16'd0;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        ST_GREEN: begin
          if (green_exit) begin
            state <= ST_YELLOW;
            tmr   <= YELLOW_CLOCKS - 16'd1;
          end else if (!max_done) begin
            g_cnt <= g_cnt + 16'd1;
          end
        end
        ST_YELLOW: begin
          if (tmr == 16'd0) begin
            state <= ST_ALL_RED;
            tmr   <= ALL_RED_CLOCKS - 16'd1;
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        default: state <= ST_STARTUP;
      endcase
    end
  end

  logic [2:0] lamp;

  always_comb begin
    o_r1_ryg     = RED;
    o_r2_ryg     = RED;
    o_r3_ryg     = RED;
    o_r4_ryg     = RED;
    o_r4_green_l = 1'b0;
    lamp         = (state == ST_GREEN) ? GRN : YEL;
    if ((state == ST_GREEN) || (state == ST_YELLOW)) begin
      case (phase_q)
        PH_NS: begin
          o_r1_ryg = lamp;
          o_r3_ryg = lamp;
        end
        PH_EW: begin
          o_r2_ryg = lamp;
          o_r4_ryg = lamp;
        end
        PH_L4: begin
          o_r4_ryg     = lamp;
          o_r4_green_l = (state == ST_GREEN);
        end
        default: ;
      endcase
    end
  end

  assign o_phase       = phase_q;
  assign o_phase_start = start_q;
  assign o_emg_active  = (state == ST_GREEN) && emg_hold;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Self-checking bench for tl_phase_scheduler: segment tables expand into per-cycle
// expectations that go through a scoreboard queue and are compared on the falling edge.
module tb_tl_phase_scheduler;

  typedef enum int {AR, NSG, NSY, EWG, EWY, L4G, L4Y} lamp_e;

  typedef struct {
    logic [2:0] req;
    logic [2:0] occ;
    logic       emg;
    logic [1:0] emg_ph;
    int         cycles;
    lamp_e      lamp;
    logic [1:0] ph;
    logic       start_first;
    logic       emg_act;
  } seg_t;

  typedef struct {
    logic [12:0] lamps;
    logic [1:0]  ph;
    logic        start;
    logic        emg_act;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] occ = '0;
  logic       emg = 1'b0;
  logic [1:0] emg_phase = '0;
  logic [2:0] r1, r2, r3, r4;
  logic       gl, pstart, emg_act;
  logic [1:0] phase;

  int   n_vec = 0;
  int   n_bad = 0;
  seg_t segs[$];
  exp_t sb[$];

  tl_phase_scheduler dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (req),
    .i_occ        (occ),
    .i_emg        (emg),
    .i_emg_phase  (emg_phase),
    .o_r1_ryg     (r1),
    .o_r2_ryg     (r2),
    .o_r3_ryg     (r3),
    .o_r4_ryg     (r4),
    .o_r4_green_l (gl),
    .o_phase      (phase),
    .o_phase_start(pstart),
    .o_emg_active (emg_act)
  );

  always #5 clk = ~clk;

  // Expected {r1, r2, r3, r4, green_l} for each visible lamp pattern.
  function automatic logic [12:0] lamp_bits(input lamp_e k);
    logic [2:0] R, Y, G;
    R = 3'b100; Y = 3'b010; G = 3'b001;
    case (k)
      NSG:     return {G, R, G, R, 1'b0};
      NSY:     return {Y, R, Y, R, 1'b0};
      EWG:     return {R, G, R, G, 1'b0};
      EWY:     return {R, Y, R, Y, 1'b0};
      L4G:     return {R, R, R, G, 1'b1};
      L4Y:     return {R, R, R, Y, 1'b0};
      default: return {R, R, R, R, 1'b0};
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [12:0] got;
    got = {r1, r2, r3, r4, gl};
    n_vec++;
    if (got !== e.lamps || phase !== e.ph || pstart !== e.start || emg_act !== e.emg_act) begin
      n_bad++;
      $display("FAIL %s: got lamps=%b phase=%0d start=%b emg=%b, expected lamps=%b phase=%0d start=%b emg=%b",
               e.name, got, phase, pstart, emg_act, e.lamps, e.ph, e.start, e.emg_act);
    end
  endtask

  task automatic add(input logic [2:0] rq, input logic [2:0] oc, input logic em, input logic [1:0] ep,
                     input int n, input lamp_e lp, input logic [1:0] ph, input logic st, input logic ea);
    seg_t s;
    s.req = rq; s.occ = oc; s.emg = em; s.emg_ph = ep; s.cycles = n;
    s.lamp = lp; s.ph = ph; s.start_first = st; s.emg_act = ea;
    segs.push_back(s);
  endtask

  // Drive each cycle just after the rising edge, compare on the falling edge.
  task automatic run(input string name);
    exp_t e;
    foreach (segs[i]) begin
      for (int c = 0; c < segs[i].cycles; c++) begin
        req       = (c == 0) ? segs[i].req : 3'b000;
        occ       = segs[i].occ;
        emg       = segs[i].emg;
        emg_phase = segs[i].emg_ph;
        e.lamps   = lamp_bits(segs[i].lamp);
        e.ph      = segs[i].ph;
        e.start   = segs[i].start_first && (c == 0);
        e.emg_act = segs[i].emg_act;
        e.name    = $sformatf("%s seg%0d cyc%0d", name, i, c);
        sb.push_back(e);
        @(negedge clk);
        check(sb.pop_front());
        @(posedge clk);
        #1;
      end
    end
    segs.delete();
  endtask

  // Asserts reset between edges, checks the immediate all-red response, then releases
  // just after a rising edge so the next run() starts in the first STARTUP cycle.
  task automatic do_reset(input string name);
    exp_t e;
    #2;
    rst_n = 1'b0; req = '0; occ = '0; emg = 1'b0; emg_phase = '0;
    #1;
    e.lamps = lamp_bits(AR); e.ph = 2'd0; e.start = 1'b0; e.emg_act = 1'b0;
    e.name = {name, " async_reset"};
    sb.push_back(e);
    check(sb.pop_front());
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Idle: two all-red cycles, then NS green rests.
    do_reset("idle");
    add(0, 0, 0, 0,   2, AR,  0, 0, 0);
    add(0, 0, 0, 0, 101, NSG, 0, 1, 0);
    run("idle");

    // Min green with EW pending; NS green afterwards rests, so pending[1] was cleared.
    do_reset("min");
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(3'b010, 0, 0, 0,  5, NSG, 0, 1, 0);
    add(0,      0, 0, 0,  2, NSY, 0, 0, 0);
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(0,      0, 0, 0, 10, EWG, 1, 1, 0);
    add(3'b001, 0, 0, 0,  2, EWG, 1, 0, 0);
    add(0,      0, 0, 0,  2, EWY, 1, 0, 0);
    add(0,      0, 0, 0,  2, AR,  1, 0, 0);
    add(0,      0, 0, 0, 30, NSG, 0, 1, 0);
    run("min");

    // Occupancy holds green to the maximum.
    do_reset("max");
    add(0,      0,      0, 0,  2, AR,  0, 0, 0);
    add(3'b010, 3'b001, 0, 0, 12, NSG, 0, 1, 0);
    add(0,      3'b001, 0, 0,  2, NSY, 0, 0, 0);
    add(0,      3'b001, 0, 0,  2, AR,  0, 0, 0);
    add(0,      0,      0, 0,  3, EWG, 1, 1, 0);
    run("max");

    // Occupancy drops in green cycle 7: yellow in cycle 8.
    do_reset("gap");
    add(0,      0,      0, 0, 2, AR,  0, 0, 0);
    add(3'b010, 3'b001, 0, 0, 6, NSG, 0, 1, 0);
    add(0,      0,      0, 0, 1, NSG, 0, 0, 0);
    add(0,      0,      0, 0, 2, NSY, 0, 0, 0);
    add(0,      0,      0, 0, 2, AR,  0, 0, 0);
    add(0,      0,      0, 0, 3, EWG, 1, 1, 0);
    run("gap");

    // Round robin after EW: L4 before NS.
    do_reset("rr");
    add(0,      0, 0, 0, 2, AR,  0, 0, 0);
    add(3'b010, 0, 0, 0, 5, NSG, 0, 1, 0);
    add(0,      0, 0, 0, 2, NSY, 0, 0, 0);
    add(0,      0, 0, 0, 2, AR,  0, 0, 0);
    add(3'b101, 0, 0, 0, 5, EWG, 1, 1, 0);
    add(0,      0, 0, 0, 2, EWY, 1, 0, 0);
    add(0,      0, 0, 0, 2, AR,  1, 0, 0);
    add(0,      0, 0, 0, 5, L4G, 2, 1, 0);
    add(0,      0, 0, 0, 2, L4Y, 2, 0, 0);
    add(0,      0, 0, 0, 2, AR,  2, 0, 0);
    add(0,      0, 0, 0, 5, NSG, 0, 1, 0);
    run("rr");

    // Emergency EW preempts NS in its first green cycle and then holds EW.
    do_reset("emg");
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(0,      0, 1, 1,  1, NSG, 0, 1, 0);
    add(0,      0, 1, 1,  2, NSY, 0, 0, 0);
    add(0,      0, 1, 1,  2, AR,  0, 0, 0);
    add(3'b001, 0, 1, 1, 20, EWG, 1, 1, 1);
    add(0,      0, 0, 0,  1, EWG, 1, 0, 0);
    add(0,      0, 0, 0,  2, EWY, 1, 0, 0);
    add(0,      0, 0, 0,  2, AR,  1, 0, 0);
    add(0,      0, 0, 0,  5, NSG, 0, 1, 0);
    run("emg");

    // Emergency phase 3 is ignored entirely.
    do_reset("emg3");
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(0,      0, 1, 3, 20, NSG, 0, 1, 0);
    add(3'b010, 0, 1, 3,  2, NSG, 0, 0, 0);
    add(0,      0, 1, 3,  2, NSY, 0, 0, 0);
    add(0,      0, 1, 3,  2, AR,  0, 0, 0);
    add(0,      0, 1, 3,  3, EWG, 1, 1, 0);
    run("emg3");

    // Emergency for the current phase pins it despite another pending phase.
    do_reset("emghold");
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(3'b010, 0, 1, 0, 15, NSG, 0, 1, 1);
    add(0,      0, 0, 0,  1, NSG, 0, 0, 0);
    add(0,      0, 0, 0,  2, NSY, 0, 0, 0);
    add(0,      0, 0, 0,  2, AR,  0, 0, 0);
    add(0,      0, 0, 0,  3, EWG, 1, 1, 0);
    run("emghold");

    // Reset in mid-yellow: immediate all-red, then a clean startup with nothing pending.
    do_reset("pre");
    add(0,      0, 0, 0, 2, AR,  0, 0, 0);
    add(3'b010, 0, 0, 0, 5, NSG, 0, 1, 0);
    add(0,      0, 0, 0, 1, NSY, 0, 0, 0);
    run("pre");
    do_reset("midyellow");
    add(0, 0, 0, 0,  2, AR,  0, 0, 0);
    add(0, 0, 0, 0, 15, NSG, 0, 1, 0);
    run("midyellow");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
